uc_serial_loader: RTL and testbench
===================================

UC_SERIAL_LOADER -- requirements
Module: uc_serial_loader

Interface
REQ-001 The block SHALL have parameter SIZESRDYN, default 16, dynamic register width.
REQ-002 The block SHALL have parameter SIZESRSTAT, default 88, static register width.
REQ-003 The block SHALL have parameter DYN_RST, default 16'h1234, DYNLATCH reset value.
REQ-004 The block SHALL have parameter STAT_RST, default 88'hABCDEF123456789ABCDEF1, STATLATCH reset value.
REQ-005 The block SHALL have port CLK, input, 1, system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port SCK, input, 1, serial clock from uC, asynchronous to CLK.
REQ-008 The block SHALL have port CS_N, input, 1, active-low frame select from uC, asynchronous.
REQ-009 The block SHALL have port MOSI, input, 1, serial data from uC, asynchronous.
REQ-010 The block SHALL have port DYNLATCH, output, SIZESRDYN, held dynamic register value.
REQ-011 The block SHALL have port STATLATCH, output, SIZESRSTAT, held static register value.
REQ-012 The block SHALL have port DYN_UPD, output, 1, one-cycle pulse on DYNLATCH update.
REQ-013 The block SHALL have port STAT_UPD, output, 1, one-cycle pulse on STATLATCH update.
REQ-014 The block SHALL have port FRM_ERR, output, 1, one-cycle pulse on a rejected frame.
REQ-015 The block SHALL have port BUSY, output, 1, high while a frame is in progress.

Function
REQ-016 SCK, CS_N and MOSI SHALL each pass through a 2-flop synchroniser; all decisions use synchronised values only.
REQ-017 A bit SHALL be sampled on each synchronised SCK rising edge while synchronised CS_N is low; uC guarantees SCK high and low phases of at least 3 CLK periods.
REQ-018 A frame SHALL be: 8-bit command, MSb first, then payload, MSb first.
REQ-019 Command 8'h01 SHALL select the dynamic register with a payload of exactly SIZESRDYN bits.
REQ-020 Command 8'h02 SHALL select the static register with a payload of exactly SIZESRSTAT bits.
REQ-021 The FSM SHALL have states IDLE, CMD, PAYLOAD and DRAIN.
REQ-022 IDLE SHALL go to CMD on synchronised CS_N falling edge, clearing the bit counter and shift register.
REQ-023 CMD SHALL go to PAYLOAD after the 8th bit if the command is 8'h01 or 8'h02, and to DRAIN otherwise (marked bad).
REQ-024 PAYLOAD SHALL shift bits into a SIZESRSTAT-wide shadow register and count them in a 7-bit counter saturating at 127.
REQ-025 DRAIN SHALL ignore SCK until CS_N rises.
REQ-026 On synchronised CS_N rising edge (cycle N), any state SHALL return to IDLE in cycle N+1.
REQ-027 A good command with payload count equal to the selected width SHALL, in cycle N+1, load the low bits of the shadow into DYNLATCH or STATLATCH and pulse DYN_UPD or STAT_UPD high for exactly that cycle.
REQ-028 A bad command, short payload, long payload, or CS_N rise during CMD SHALL, in cycle N+1, pulse FRM_ERR high and leave both latches unchanged.
REQ-029 A CS_N rise while in IDLE (no frame) SHALL produce no pulse.
REQ-030 DYN_UPD, STAT_UPD and FRM_ERR SHALL be mutually exclusive in every cycle.
REQ-031 BUSY SHALL be high in CMD, PAYLOAD and DRAIN, and low in IDLE.
REQ-032 DYNLATCH and STATLATCH SHALL change only as defined in REQ-027 and under reset.

Reset
REQ-033 While RST is high at a CLK edge, the FSM SHALL enter IDLE, counter and shadow SHALL clear, and synchronisers SHALL load 1 (CS_N, SCK) and 0 (MOSI).
REQ-034 While RST is high, DYNLATCH SHALL be DYN_RST and STATLATCH SHALL be STAT_RST, and DYN_UPD, STAT_UPD, FRM_ERR and BUSY SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no pulse; the next frame after reset SHALL start cleanly from a CS_N fall.

Verification
REQ-036 Reset check: after RST, without serial traffic -> DYNLATCH=16'h1234, STATLATCH=88'hABCDEF123456789ABCDEF1, all pulses 0, BUSY 0.
REQ-037 Dynamic frame: frame 8'h01 + 16'hBEEF -> DYNLATCH=16'hBEEF, one DYN_UPD pulse, STATLATCH unchanged.
REQ-038 Static frame: frame 8'h02 + 88'h0123456789ABCDEF012345 -> STATLATCH updated to that value, one STAT_UPD pulse.
REQ-039 Length errors: 8'h01 + 15 bits, then 8'h01 + 17 bits -> two FRM_ERR pulses, DYNLATCH unchanged.
REQ-040 Bad command: 8'h07 + 16 bits -> one FRM_ERR pulse, BUSY high until CS_N rises, no latch change.
REQ-041 Reset mid-frame: RST pulsed after 40 bits of a static frame, then frame 8'h01 + 16'h0F0F -> no FRM_ERR, DYNLATCH=16'h0F0F.

Source files
------------

// File: rtl/uc_serial_loader.sv
// Serial register loader: a uC shifts an 8-bit command and a payload over SCK/CS_N/MOSI,
// and a complete, well-formed frame updates either the dynamic or the static holding register.
module uc_serial_loader #(
    parameter int                    SIZESRDYN  = 16,
    parameter int                    SIZESRSTAT = 88,
    parameter logic [SIZESRDYN-1:0]  DYN_RST    = 16'h1234,
    parameter logic [SIZESRSTAT-1:0] STAT_RST   = 88'hABCDEF123456789ABCDEF1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic [SIZESRDYN-1:0]  DYNLATCH,
    output logic [SIZESRSTAT-1:0] STATLATCH,
    output logic                  DYN_UPD,
    output logic                  STAT_UPD,
    output logic                  FRM_ERR,
    output logic                  BUSY
);

    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, DRAIN} state_t;

    localparam logic [7:0] CMD_DYN  = 8'h01;
    localparam logic [7:0] CMD_STAT = 8'h02;
    localparam logic [6:0] DYN_LEN  = 7'(SIZESRDYN);
    localparam logic [6:0] STAT_LEN = 7'(SIZESRSTAT);
    localparam logic [6:0] CNT_MAX  = 7'h7F;

    logic sck_meta, sck_sync, sck_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;

    state_t                  state, state_nxt;
    logic [6:0]              cnt, cnt_nxt;
    logic [7:0]              cmd, cmd_nxt, cmd_shift;
    logic [SIZESRSTAT-1:0]   shadow, shadow_nxt;
    logic                    dyn_upd_nxt, stat_upd_nxt, frm_err_nxt;

    logic sck_rise, cs_fall, cs_rise, bit_take;

    // Idle values match a deselected bus so that reset never fakes a CS_N edge.
    // NOTE: every flop is written with <= so all registers update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_meta  <= 1'b1;
            sck_sync  <= 1'b1;
            sck_prev  <= 1'b1;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= CS_N;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign cs_fall  = ~cs_sync & cs_prev;
    assign cs_rise  = cs_sync & ~cs_prev;
    assign bit_take = sck_rise & ~cs_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd       <= '0;
            shadow    <= '0;
            DYN_UPD   <= 1'b0;
            STAT_UPD  <= 1'b0;
            FRM_ERR   <= 1'b0;
            DYNLATCH  <= DYN_RST;
            STATLATCH <= STAT_RST;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cmd      <= cmd_nxt;
            shadow   <= shadow_nxt;
            DYN_UPD  <= dyn_upd_nxt;
            STAT_UPD <= stat_upd_nxt;
            FRM_ERR  <= frm_err_nxt;
            if (dyn_upd_nxt) begin
                DYNLATCH <= shadow[SIZESRDYN-1:0];
            end
            if (stat_upd_nxt) begin
                STATLATCH <= shadow;
            end
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cmd_nxt      = cmd;
        shadow_nxt   = shadow;
        dyn_upd_nxt  = 1'b0;
        stat_upd_nxt = 1'b0;
        frm_err_nxt  = 1'b0;
        cmd_shift    = {cmd[6:0], mosi_sync};

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt  = CMD;
                    cnt_nxt    = '0;
                    cmd_nxt    = '0;
                    shadow_nxt = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_nxt   = IDLE;
                    frm_err_nxt = 1'b1;
                end else if (bit_take) begin
                    cmd_nxt = cmd_shift;
                    if (cnt == 7'd7) begin
                        cnt_nxt   = '0;
                        state_nxt = (cmd_shift == CMD_DYN || cmd_shift == CMD_STAT) ? PAYLOAD : DRAIN;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    if (cmd == CMD_DYN && cnt == DYN_LEN) begin
                        dyn_upd_nxt = 1'b1;
                    end else if (cmd == CMD_STAT && cnt == STAT_LEN) begin
                        stat_upd_nxt = 1'b1;
                    end else begin
                        frm_err_nxt = 1'b1;
                    end
                end else if (bit_take) begin
                    shadow_nxt = {shadow[SIZESRSTAT-2:0], mosi_sync};
                    // Saturation keeps an over-long payload from wrapping back to a valid length.
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
            end
            DRAIN: begin
                if (cs_rise) begin
                    state_nxt   = IDLE;
                    frm_err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uc_serial_loader.sv
// Self-checking bench for uc_serial_loader: directed and random frames against a frame-level
// model that predicts the outcome from command, bit count and payload only.
module tb_uc_serial_loader;

    localparam int DW = 16;
    localparam int SW = 88;
    localparam logic [DW-1:0] DYN_DEF  = 16'h1234;
    localparam logic [SW-1:0] STAT_DEF = 88'hABCDEF123456789ABCDEF1;

    logic          CLK  = 1'b0;
    logic          RST  = 1'b1;
    logic          SCK  = 1'b0;
    logic          CS_N = 1'b1;
    logic          MOSI = 1'b0;
    logic [DW-1:0] DYNLATCH;
    logic [SW-1:0] STATLATCH;
    logic          DYN_UPD, STAT_UPD, FRM_ERR, BUSY;

    uc_serial_loader dut (
        .CLK       (CLK),
        .RST       (RST),
        .SCK       (SCK),
        .CS_N      (CS_N),
        .MOSI      (MOSI),
        .DYNLATCH  (DYNLATCH),
        .STATLATCH (STATLATCH),
        .DYN_UPD   (DYN_UPD),
        .STAT_UPD  (STAT_UPD),
        .FRM_ERR   (FRM_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Per-cycle observer: counts pulse cycles and records rule violations for later checking.
    int            n_dyn  = 0;
    int            n_stat = 0;
    int            n_err  = 0;
    int            n_viol = 0;
    logic [DW-1:0] prev_dyn  = '0;
    logic [SW-1:0] prev_stat = '0;

    always @(negedge CLK) begin
        if (DYN_UPD === 1'b1)  n_dyn++;
        if (STAT_UPD === 1'b1) n_stat++;
        if (FRM_ERR === 1'b1)  n_err++;
        if (!$onehot0({DYN_UPD, STAT_UPD, FRM_ERR})) n_viol++;
        if (!RST && DYNLATCH !== prev_dyn && DYN_UPD !== 1'b1) n_viol++;
        if (!RST && STATLATCH !== prev_stat && STAT_UPD !== 1'b1) n_viol++;
        prev_dyn  = DYNLATCH;
        prev_stat = STATLATCH;
    end

    logic [DW-1:0] exp_dyn  = DYN_DEF;
    logic [SW-1:0] exp_stat = STAT_DEF;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // SCK phases of 4 CLK periods each, MOSI set up during the low phase.
    task automatic send_bit(input logic b);
        MOSI = b;
        SCK  = 1'b0;
        wait_clks(4);
        SCK = 1'b1;
        wait_clks(4);
        SCK = 1'b0;
    endtask

    task automatic check_latches(input string tag);
        check({tag, " dyn"},  160'(DYNLATCH),  160'(exp_dyn));
        check({tag, " stat"}, 160'(STATLATCH), 160'(exp_stat));
    endtask

    // Sends ncmd command bits (ncmd < 8 aborts during the command) then nbits payload bits.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input int ncmd,
                             input logic [159:0] pay, input int nbits);
        int d0 = n_dyn;
        int s0 = n_stat;
        int e0 = n_err;
        int want_d = 0;
        int want_s = 0;
        int want_e = 0;
        CS_N = 1'b0;
        wait_clks(6);
        check({tag, " busy start"}, 160'(BUSY), 160'(1));
        for (int i = 7; i > 7 - ncmd; i--) send_bit(cmd[i]);
        if (ncmd == 8) begin
            for (int i = nbits - 1; i >= 0; i--) send_bit(pay[i]);
        end
        wait_clks(4);
        check({tag, " busy end"}, 160'(BUSY), 160'(1));
        CS_N = 1'b1;
        wait_clks(8);

        if (ncmd < 8) begin
            want_e = 1;
        end else if (cmd == 8'h01 && nbits == DW) begin
            want_d  = 1;
            exp_dyn = pay[DW-1:0];
        end else if (cmd == 8'h02 && nbits == SW) begin
            want_s   = 1;
            exp_stat = pay[SW-1:0];
        end else begin
            want_e = 1;
        end

        check({tag, " dyn_upd count"},  160'(n_dyn - d0),  160'(want_d));
        check({tag, " stat_upd count"}, 160'(n_stat - s0), 160'(want_s));
        check({tag, " frm_err count"},  160'(n_err - e0),  160'(want_e));
        check({tag, " busy idle"},      160'(BUSY),        160'(0));
        check_latches(tag);
    endtask

    initial begin
        logic [159:0] pay;
        logic [7:0]   rcmd;
        int           sel, base, nb, d0, s0, e0;

        // Reset, including a check while RST is still high.
        wait_clks(4);
        check("rst dyn",      160'(DYNLATCH),  160'(DYN_DEF));
        check("rst stat",     160'(STATLATCH), 160'(STAT_DEF));
        check("rst pulses",   160'({DYN_UPD, STAT_UPD, FRM_ERR}), 160'(0));
        check("rst busy",     160'(BUSY), 160'(0));
        RST = 1'b0;
        wait_clks(10);
        check("idle pulses",  160'(n_dyn + n_stat + n_err), 160'(0));
        check("idle busy",    160'(BUSY), 160'(0));
        check_latches("idle");

        // Directed frames.
        run_frame("dyn beef",    8'h01, 8, 160'h0BEEF, 16);
        run_frame("stat frame",  8'h02, 8, 160'h0123456789ABCDEF012345, 88);
        run_frame("dyn short",   8'h01, 8, 160'h1ABC, 15);
        run_frame("dyn long",    8'h01, 8, 160'h1ABCD, 17);
        run_frame("bad cmd",     8'h07, 8, 160'h5A5A, 16);
        run_frame("cmd abort",   8'h01, 3, 160'h0, 0);
        run_frame("empty frame", 8'h01, 0, 160'h0, 0);
        run_frame("stat on dyn len", 8'h02, 8, 160'hCAFE, 16);
        run_frame("dyn 144 bits", 8'h01, 8, {5{32'h9E3779B9}}, 144);

        // Reset in the middle of a static frame, uC deselects while reset is held.
        d0 = n_dyn;
        s0 = n_stat;
        e0 = n_err;
        CS_N = 1'b0;
        wait_clks(6);
        for (int i = 7; i >= 0; i--) send_bit(((8'h02 >> i) & 8'h01) != 0);
        for (int i = 0; i < 32; i++) send_bit(1'($urandom));
        RST = 1'b1;
        wait_clks(2);
        CS_N = 1'b1;
        wait_clks(4);
        exp_dyn  = DYN_DEF;
        exp_stat = STAT_DEF;
        check("midrst busy", 160'(BUSY), 160'(0));
        check_latches("midrst");
        RST = 1'b0;
        wait_clks(6);
        check("midrst pulses", 160'((n_dyn - d0) + (n_stat - s0) + (n_err - e0)), 160'(0));
        run_frame("after rst 0f0f", 8'h01, 8, 160'h0F0F, 16);

        // Random frames around the legal lengths.
        for (int k = 0; k < 12; k++) begin
            sel = int'($urandom_range(0, 3));
            rcmd = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom);
            base = (rcmd == 8'h02) ? SW : DW;
            case ($urandom_range(0, 3))
                0: nb = base;
                1: nb = base - 1;
                2: nb = base + 1;
                default: nb = int'($urandom_range(0, 130));
            endcase
            pay = {$urandom, $urandom, $urandom, $urandom, $urandom};
            run_frame($sformatf("rand%0d cmd%0h len%0d", k, rcmd, nb), rcmd, 8, pay, nb);
        end

        check("pulse exclusivity and latch stability", 160'(n_viol), 160'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
